// File: rtl/st_wide_to_narrow_dfa.sv
// rtl/st_wide_to_narrow_dfa.sv - wide-to-narrow streaming data format adapter
module st_wide_to_narrow_dfa #(
  parameter int SYMBOL_W    = 8,
  parameter int IN_SYMBOLS  = 8,
  parameter int OUT_SYMBOLS = 4,
  parameter int IN_EMPTY_W  = 3,
  parameter int OUT_EMPTY_W = 2,
  parameter int CHANNEL_W   = 1,
  parameter int ERROR_W     = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  output logic                            in_ready,
  input  logic                            in_valid,
  input  logic [IN_SYMBOLS*SYMBOL_W-1:0]  in_data,
  input  logic [CHANNEL_W-1:0]            in_channel,
  input  logic [ERROR_W-1:0]              in_error,
  input  logic                            in_startofpacket,
  input  logic                            in_endofpacket,
  input  logic [IN_EMPTY_W-1:0]           in_empty,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [OUT_SYMBOLS*SYMBOL_W-1:0] out_data,
  output logic [CHANNEL_W-1:0]            out_channel,
  output logic [ERROR_W-1:0]              out_error,
  output logic                            out_startofpacket,
  output logic                            out_endofpacket,
  output logic [OUT_EMPTY_W-1:0]          out_empty
);

  localparam int RATIO = IN_SYMBOLS / OUT_SYMBOLS;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IN_W  = IN_SYMBOLS * SYMBOL_W;
  localparam int OUT_W = OUT_SYMBOLS * SYMBOL_W;

  // Input holding register
  logic                   a_valid_q, a_valid_d;
  logic [IN_W-1:0]        a_data_q, a_data_d;
  logic [CHANNEL_W-1:0]   a_channel_q, a_channel_d;
  logic [ERROR_W-1:0]     a_error_q, a_error_d;
  logic                   a_sop_q, a_sop_d;
  logic                   a_eop_q, a_eop_d;
  logic [IN_EMPTY_W-1:0]  a_empty_q, a_empty_d;

  // Slice index into the held beat
  logic [IDX_W-1:0]       idx_q, idx_d;

  // Output register
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic [CHANNEL_W-1:0]   out_channel_q, out_channel_d;
  logic [ERROR_W-1:0]     out_error_q, out_error_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [OUT_EMPTY_W-1:0] out_empty_q, out_empty_d;

  // Slice control
  logic adv;
  logic emit;
  logic last_slice;
  int   tail_syms;

  // Decide whether the output stage moves and whether the current slice ends the held beat.
  // tail_syms is the number of symbols in the held beat after the current slice; once the
  // EOP beat's empty count covers all of them, nothing useful remains and the beat retires early.
  always_comb begin
    adv        = out_ready || !out_valid_q;
    emit       = adv && a_valid_q;
    tail_syms  = (RATIO - 1 - int'(idx_q)) * OUT_SYMBOLS;
    last_slice = (idx_q == IDX_W'(RATIO - 1)) ||
                 (a_eop_q && (int'(a_empty_q) >= tail_syms));
  end

  // The holding register frees up in the same cycle its last slice is emitted.
  assign in_ready = !a_valid_q || (emit && last_slice);

  // Next state of the holding register: load a new beat whenever there is room for it.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_data_d    = a_data_q;
    a_channel_d = a_channel_q;
    a_error_d   = a_error_q;
    a_sop_d     = a_sop_q;
    a_eop_d     = a_eop_q;
    a_empty_d   = a_empty_q;
    if (in_ready) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_data_d    = in_data;
        a_channel_d = in_channel;
        a_error_d   = in_error;
        a_sop_d     = in_startofpacket;
        a_eop_d     = in_endofpacket;
        a_empty_d   = in_endofpacket ? in_empty : '0;
      end
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q   <= 1'b0;
      a_data_q    <= '0;
      a_channel_q <= '0;
      a_error_q   <= '0;
      a_sop_q     <= 1'b0;
      a_eop_q     <= 1'b0;
      a_empty_q   <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_data_q    <= a_data_d;
      a_channel_q <= a_channel_d;
      a_error_q   <= a_error_d;
      a_sop_q     <= a_sop_d;
      a_eop_q     <= a_eop_d;
      a_empty_q   <= a_empty_d;
    end
  end

  // Next state of the output register and slice index. Everything holds while the
  // downstream stalls a valid beat; symbol 0 sits in the MSBs so slice idx is taken
  // counting down from the top of the held word.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_error_d   = out_error_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    idx_d         = idx_q;
    if (adv) begin
      out_valid_d = a_valid_q;
      if (a_valid_q) begin
        out_data_d    = a_data_q[IN_W - 1 - int'(idx_q) * OUT_W -: OUT_W];
        out_channel_d = a_channel_q;
        out_error_d   = a_error_q;
        out_sop_d     = a_sop_q && (idx_q == '0);
        out_eop_d     = a_eop_q && last_slice;
        out_empty_d   = (a_eop_q && last_slice) ?
                        OUT_EMPTY_W'(int'(a_empty_q) - tail_syms) : '0;
        idx_d         = last_slice ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Output register and slice index state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_error_q   <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      idx_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_error_q   <= out_error_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      idx_q         <= idx_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_channel       = out_channel_q;
  assign out_error         = out_error_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_empty         = out_empty_q;

  // An empty count covering the whole beat is illegal; only checkable when the field can encode it.
  if ((1 << IN_EMPTY_W) > IN_SYMBOLS) begin : g_empty_range_chk
    a_empty_range: assert property (@(posedge clk) disable iff (!reset_n)
      (in_valid && in_endofpacket) |-> (int'(in_empty) < IN_SYMBOLS));
  end

endmodule

// File: tb/tb_st_wide_to_narrow_dfa.sv
// tb/tb_st_wide_to_narrow_dfa.sv - bench for the wide-to-narrow adapter in three geometries
module tb_st_wide_to_narrow_dfa;

  typedef struct packed {
    logic [63:0] data;
    logic        ch;
    logic        err;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  logic clk;
  logic reset_n;

  // Index 0: 8->4 symbols, 1: 4->1 symbols, 2: 4->4 symbols (passthrough)
  logic        in_valid_v [3];
  logic [63:0] in_data_v  [3];
  logic        in_ch_v    [3];
  logic        in_err_v   [3];
  logic        in_sop_v   [3];
  logic        in_eop_v   [3];
  logic [2:0]  in_empty_v [3];
  logic        out_ready_v[3];
  logic        rmode      [3];

  logic        in_ready_w [3];
  logic        ov   [3];
  logic [63:0] od   [3];
  logic        och  [3];
  logic        oer  [3];
  logic        osop [3];
  logic        oeop [3];
  logic [2:0]  oemp [3];

  logic        in_ready0, out_valid0, out_ch0, out_err0, out_sop0, out_eop0;
  logic [31:0] out_data0;
  logic [1:0]  out_empty0;
  logic        in_ready1, out_valid1, out_ch1, out_err1, out_sop1, out_eop1;
  logic [7:0]  out_data1;
  logic [0:0]  out_empty1;
  logic        in_ready2, out_valid2, out_ch2, out_err2, out_sop2, out_eop2;
  logic [31:0] out_data2;
  logic [1:0]  out_empty2;

  beat_t exp_q [3][$];
  int    nbeats[3];
  logic  stall_q[3];
  logic [63:0] prev_data[3];
  logic [7:0]  prev_flags[3];

  int checks = 0;
  int errors = 0;

  st_wide_to_narrow_dfa u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready0), .in_valid(in_valid_v[0]),
    .in_data(in_data_v[0]), .in_channel(in_ch_v[0]), .in_error(in_err_v[0]),
    .in_startofpacket(in_sop_v[0]), .in_endofpacket(in_eop_v[0]), .in_empty(in_empty_v[0]),
    .out_ready(out_ready_v[0]), .out_valid(out_valid0), .out_data(out_data0),
    .out_channel(out_ch0), .out_error(out_err0), .out_startofpacket(out_sop0),
    .out_endofpacket(out_eop0), .out_empty(out_empty0)
  );

  st_wide_to_narrow_dfa #(
    .SYMBOL_W(8), .IN_SYMBOLS(4), .OUT_SYMBOLS(1), .IN_EMPTY_W(2), .OUT_EMPTY_W(1),
    .CHANNEL_W(1), .ERROR_W(1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready1), .in_valid(in_valid_v[1]),
    .in_data(in_data_v[1][31:0]), .in_channel(in_ch_v[1]), .in_error(in_err_v[1]),
    .in_startofpacket(in_sop_v[1]), .in_endofpacket(in_eop_v[1]), .in_empty(in_empty_v[1][1:0]),
    .out_ready(out_ready_v[1]), .out_valid(out_valid1), .out_data(out_data1),
    .out_channel(out_ch1), .out_error(out_err1), .out_startofpacket(out_sop1),
    .out_endofpacket(out_eop1), .out_empty(out_empty1)
  );

  st_wide_to_narrow_dfa #(
    .SYMBOL_W(8), .IN_SYMBOLS(4), .OUT_SYMBOLS(4), .IN_EMPTY_W(2), .OUT_EMPTY_W(2),
    .CHANNEL_W(1), .ERROR_W(1)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready2), .in_valid(in_valid_v[2]),
    .in_data(in_data_v[2][31:0]), .in_channel(in_ch_v[2]), .in_error(in_err_v[2]),
    .in_startofpacket(in_sop_v[2]), .in_endofpacket(in_eop_v[2]), .in_empty(in_empty_v[2][1:0]),
    .out_ready(out_ready_v[2]), .out_valid(out_valid2), .out_data(out_data2),
    .out_channel(out_ch2), .out_error(out_err2), .out_startofpacket(out_sop2),
    .out_endofpacket(out_eop2), .out_empty(out_empty2)
  );

  assign in_ready_w[0] = in_ready0;
  assign in_ready_w[1] = in_ready1;
  assign in_ready_w[2] = in_ready2;
  assign ov[0] = out_valid0;  assign ov[1] = out_valid1;  assign ov[2] = out_valid2;
  assign od[0] = {32'd0, out_data0};
  assign od[1] = {56'd0, out_data1};
  assign od[2] = {32'd0, out_data2};
  assign och[0] = out_ch0;    assign och[1] = out_ch1;    assign och[2] = out_ch2;
  assign oer[0] = out_err0;   assign oer[1] = out_err1;   assign oer[2] = out_err2;
  assign osop[0] = out_sop0;  assign osop[1] = out_sop1;  assign osop[2] = out_sop2;
  assign oeop[0] = out_eop0;  assign oeop[1] = out_eop1;  assign oeop[2] = out_eop2;
  assign oemp[0] = {1'b0, out_empty0};
  assign oemp[1] = {2'b0, out_empty1};
  assign oemp[2] = {1'b0, out_empty2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int isym(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic int osym(input int d);
    return (d == 1) ? 1 : 4;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an accepted beat carries is-empty valid symbols, which fill
  // ceil(valid/os) narrow beats; the last of those pads with (beats*os - valid) empties.
  task automatic push_beat(input int d);
    int is, os, valid, n;
    beat_t b;
    is    = isym(d);
    os    = osym(d);
    valid = is - (in_eop_v[d] ? int'(in_empty_v[d]) : 0);
    n     = in_eop_v[d] ? (valid + os - 1) / os : is / os;
    for (int k = 0; k < n; k++) begin
      b.data  = (in_data_v[d] >> ((is - (k + 1) * os) * 8)) & ((64'd1 << (os * 8)) - 64'd1);
      b.ch    = in_ch_v[d];
      b.err   = in_err_v[d];
      b.sop   = in_sop_v[d] && (k == 0);
      b.eop   = in_eop_v[d] && (k == n - 1);
      b.empty = b.eop ? 3'(n * os - valid) : 3'd0;
      exp_q[d].push_back(b);
    end
  endtask

  // Downstream ready: constant 1 or a random stall pattern
  initial begin
    for (int d = 0; d < 3; d++) out_ready_v[d] = 1'b1;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        out_ready_v[d] = rmode[d] ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Compare process: sampled between the input drive point and the next rising edge
  initial begin
    beat_t b;
    for (int d = 0; d < 3; d++) begin
      nbeats[d] = 0;
      stall_q[d] = 1'b0;
      prev_data[d] = '0;
      prev_flags[d] = '0;
    end
    forever begin
      @(negedge clk);
      #3;
      for (int d = 0; d < 3; d++) begin
        if (!reset_n) begin
          exp_q[d].delete();
          stall_q[d] = 1'b0;
        end else begin
          if (stall_q[d]) begin
            check($sformatf("d%0d_stall_data", d), od[d], prev_data[d]);
            check($sformatf("d%0d_stall_flags", d),
                  {ov[d], och[d], oer[d], osop[d], oeop[d], oemp[d]}, prev_flags[d]);
          end
          if (ov[d] && out_ready_v[d]) begin
            nbeats[d]++;
            check($sformatf("d%0d_beat_expected", d), 64'(exp_q[d].size() > 0), 64'd1);
            if (exp_q[d].size() > 0) begin
              b = exp_q[d].pop_front();
              check($sformatf("d%0d_data", d), od[d], b.data);
              check($sformatf("d%0d_chan_err", d), {och[d], oer[d]}, {b.ch, b.err});
              check($sformatf("d%0d_sop", d), osop[d], b.sop);
              check($sformatf("d%0d_eop", d), oeop[d], b.eop);
              check($sformatf("d%0d_empty", d), oemp[d], b.empty);
            end
          end
          if (in_valid_v[d] && in_ready_w[d]) push_beat(d);
          stall_q[d]    = ov[d] && !out_ready_v[d];
          prev_data[d]  = od[d];
          prev_flags[d] = {ov[d], och[d], oer[d], osop[d], oeop[d], oemp[d]};
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present one beat and hold it until the adapter takes it (called at negedge+1)
  task automatic send(input int d, input logic [63:0] data, input logic ch, input logic err,
                      input logic sop, input logic eop, input logic [2:0] empty);
    int n;
    in_data_v[d]  = data;
    in_ch_v[d]    = ch;
    in_err_v[d]   = err;
    in_sop_v[d]   = sop;
    in_eop_v[d]   = eop;
    in_empty_v[d] = empty;
    in_valid_v[d] = 1'b1;
    n = 0;
    while (!in_ready_w[d] && n < 500) begin
      step();
      n++;
    end
    check($sformatf("d%0d_send_ready", d), in_ready_w[d], 1'b1);
    step();
    in_valid_v[d] = 1'b0;
  endtask

  task automatic expect_out(input int d, input logic valid, input logic [63:0] data,
                            input logic sop, input logic eop, input logic [2:0] empty);
    check($sformatf("d%0d_lit_valid", d), ov[d], valid);
    if (valid) begin
      check($sformatf("d%0d_lit_data", d), od[d], data);
      check($sformatf("d%0d_lit_sop_eop", d), {osop[d], oeop[d]}, {sop, eop});
      check($sformatf("d%0d_lit_empty", d), oemp[d], empty);
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((exp_q[d].size() != 0 || ov[d]) && n < 300) begin
      step();
      n++;
    end
    check($sformatf("d%0d_drained", d), 64'(exp_q[d].size()), 64'd0);
  endtask

  initial begin
    int base;
    logic [63:0] d1, d2, s1, s2;
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rmode[d] = 1'b0;
      in_valid_v[d] = 1'b0;
      in_data_v[d] = '0;
      in_ch_v[d] = 1'b0;
      in_err_v[d] = 1'b0;
      in_sop_v[d] = 1'b0;
      in_eop_v[d] = 1'b0;
      in_empty_v[d] = '0;
    end
    #2;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_rst_valid", d), ov[d], 1'b0);
      check($sformatf("d%0d_rst_in_ready", d), in_ready_w[d], 1'b1);
      check($sformatf("d%0d_rst_data", d), od[d], 64'd0);
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // Single SOP+EOP beat, full
    send(0, 64'h0011223344556677, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    expect_out(0, 1'b0, 64'd0, 1'b0, 1'b0, 3'd0);
    step();
    expect_out(0, 1'b1, 64'h00112233, 1'b1, 1'b0, 3'd0);
    step();
    expect_out(0, 1'b1, 64'h44556677, 1'b0, 1'b1, 3'd0);
    step();
    expect_out(0, 1'b0, 64'd0, 1'b0, 1'b0, 3'd0);

    // Early termination at slice 0 and back-to-back follow-on packet
    send(0, 64'hA0A1A2A3A4A5A6A7, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
    check("d0_early_in_ready", in_ready_w[0], 1'b1);
    send(0, 64'hB0B1B2B3B4B5B6B7, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    expect_out(0, 1'b1, 64'hA0A1A2A3, 1'b1, 1'b1, 3'd1);
    step();
    expect_out(0, 1'b1, 64'hB0B1B2B3, 1'b1, 1'b0, 3'd0);
    repeat (3) step();

    // Empty 4: one slice only; empty 3: two slices, second padded by 3
    send(0, 64'hC0C1C2C3C4C5C6C7, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4);
    step();
    expect_out(0, 1'b1, 64'hC0C1C2C3, 1'b1, 1'b1, 3'd0);
    step();
    expect_out(0, 1'b0, 64'd0, 1'b0, 1'b0, 3'd0);
    send(0, 64'hD0D1D2D3D4D5D6D7, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    step();
    expect_out(0, 1'b1, 64'hD0D1D2D3, 1'b1, 1'b0, 3'd0);
    step();
    expect_out(0, 1'b1, 64'hD4D5D6D7, 1'b0, 1'b1, 3'd3);
    step();
    expect_out(0, 1'b0, 64'd0, 1'b0, 1'b0, 3'd0);

    // Channel and error replicated on both slices
    send(0, 64'h1122334455667788, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    step();
    check("d0_ch_err_slice0", {och[0], oer[0]}, 2'b11);
    step();
    check("d0_ch_err_slice1", {och[0], oer[0]}, 2'b11);
    repeat (2) step();

    // 16 back-to-back beats under random backpressure
    base = nbeats[0];
    rmode[0] = 1'b1;
    for (int i = 0; i < 16; i++)
      send(0, {$urandom, $urandom}, 1'(i), 1'(i >> 1), (i % 4) == 0, (i % 4) == 3,
           ((i % 4) == 3) ? 3'(i / 4) : 3'd0);
    rmode[0] = 1'b0;
    drain(0);
    check("d0_stream_beats", 64'(nbeats[0] - base), 64'd32);

    // Reset mid-packet in each geometry, then a fresh packet
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin d1 = 64'h0123456789ABCDEF; s1 = 64'h01234567; d2 = 64'hFEDCBA9876543210; s2 = 64'hFEDCBA98; end
        1: begin d1 = 64'hA1B2C3D4; s1 = 64'hA1; d2 = 64'h55667788; s2 = 64'h55; end
        default: begin d1 = 64'hA1B2C3D4; s1 = 64'hA1B2C3D4; d2 = 64'h55667788; s2 = 64'h55667788; end
      endcase
      send(d, d1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      step();
      expect_out(d, 1'b1, s1, 1'b1, 1'b0, 3'd0);
      step();
      reset_n = 1'b0;
      #1;
      check($sformatf("d%0d_midrst_outs", d),
            {ov[d], osop[d], oeop[d], oemp[d], och[d], oer[d]}, 64'd0);
      check($sformatf("d%0d_midrst_data", d), od[d], 64'd0);
      check($sformatf("d%0d_midrst_in_ready", d), in_ready_w[d], 1'b1);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      send(d, d2, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
      step();
      expect_out(d, 1'b1, s2, 1'b1, d == 2, 3'd0);
      drain(d);
    end

    // Short tail in the narrow geometries
    send(1, 64'h0A0B0C0D, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
    send(2, 64'h0A0B0C0D, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
    drain(1);
    drain(2);
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
